sophiali_math_driver: RTL and testbench

SOPHIALI_MATH_DRIVER -- requirements
Module: sophiali_math_driver

---
 rtl/sophiali_math_driver_pkg.sv | 31 +++
 rtl/sophiali_math_driver_en_pulser.sv | 74 +++++++
 rtl/sophiali_math_driver.sv | 135 +++++++++++++
 tb/tb_sophiali_math_driver.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sophiali_math_driver_pkg.sv
// Shared types and constants for the calculator driver and its en pulser.
package sophiali_math_driver_pkg;

  // Calculator opcodes as seen on arithOp.
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_XOR = 2'b10,
    OP_LSH = 2'b11
  } arith_op_t;

  // Top-level sequencing states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PULSE = 2'b01,
    S_GAP   = 2'b10,
    S_CHECK = 2'b11
  } drv_state_t;

  // Phases of the en pulse generator.
  typedef enum logic [1:0] {
    PH_IDLE = 2'b00,
    PH_HIGH = 2'b01,
    PH_LOW  = 2'b10
  } pulse_phase_t;

  // Number of calculator operations issued per sequence.
  localparam int unsigned STEP_COUNT = 7;
  localparam logic [2:0]  STEP_LAST  = 3'(STEP_COUNT - 1);

endpackage

// File: rtl/sophiali_math_driver_en_pulser.sv
// Generates one en pulse of EN_HIGH cycles followed by EN_LOW low cycles per go.
// A go arriving in the last low cycle chains straight into the next pulse.
module sophiali_en_pulser
  import sophiali_math_driver_pkg::*;
#(
  parameter int unsigned EN_HIGH = 1,
  parameter int unsigned EN_LOW  = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic go,
  output logic en,
  output logic high_last,
  output logic finished
);

  localparam logic [3:0] HIGH_LAST = 4'(EN_HIGH - 1);
  localparam logic [3:0] LOW_LAST  = 4'(EN_LOW - 1);

  pulse_phase_t phase_q, phase_d;
  logic [3:0]   cnt_q, cnt_d;

  // Phase and cycle counter registers; reset parks the pulser with en low.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q <= PH_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  // Phase sequencing and the last-cycle handshake flags.
  always_comb begin
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    high_last = 1'b0;
    finished  = 1'b0;
    case (phase_q)
      PH_IDLE: begin
        if (go) begin
          phase_d = PH_HIGH;
          cnt_d   = 4'd0;
        end
      end
      PH_HIGH: begin
        if (cnt_q == HIGH_LAST) begin
          high_last = 1'b1;
          phase_d   = PH_LOW;
          cnt_d     = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      PH_LOW: begin
        if (cnt_q == LOW_LAST) begin
          finished = 1'b1;
          cnt_d    = 4'd0;
          phase_d  = go ? PH_HIGH : PH_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        phase_d = PH_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign en = (phase_q == PH_HIGH);

endmodule

// File: rtl/sophiali_math_driver.sv
// Drives a small accumulator calculator to a requested 8-bit value using a
// fixed seven-operation recipe: two shifts to clear, then five ops to build it.
module sophiali_math_driver
  import sophiali_math_driver_pkg::*;
#(
  parameter int unsigned EN_HIGH = 1,
  parameter int unsigned EN_LOW  = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] target,
  input  logic [7:0] calc_out,
  output logic       en,
  output logic [2:0] in,
  output logic [1:0] arithOp,
  output logic       busy,
  output logic       done,
  output logic       match
);

  drv_state_t state_q, state_d;
  logic [2:0] step_q, step_d;
  logic [7:0] target_q;
  logic       match_q;
  logic       go;
  logic       capture;
  logic       check_now;
  logic       high_last;
  logic       finished;
  logic       pulser_en;
  arith_op_t  op_sel;
  logic [2:0] operand_sel;

  sophiali_en_pulser #(
    .EN_HIGH(EN_HIGH),
    .EN_LOW (EN_LOW)
  ) u_pulser (
    .clock    (clock),
    .reset    (reset),
    .go       (go),
    .en       (pulser_en),
    .high_last(high_last),
    .finished (finished)
  );

  // Sequencing: IDLE accepts start, PULSE/GAP follow the pulser, CHECK reports.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    go        = 1'b0;
    capture   = 1'b0;
    check_now = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PULSE;
          step_d  = 3'd0;
          go      = 1'b1;
          capture = 1'b1;
        end
      end
      S_PULSE: begin
        if (high_last) begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (finished) begin
          if (step_q == STEP_LAST) begin
            state_d   = S_CHECK;
            check_now = 1'b1;
          end else begin
            state_d = S_PULSE;
            step_d  = step_q + 3'd1;
            go      = 1'b1;
          end
        end
      end
      S_CHECK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, step, latched target and match; match is sampled on entry to
  // CHECK so it is already valid in the same cycle that done is high.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      step_q   <= 3'd0;
      target_q <= 8'd0;
      match_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      if (capture) begin
        target_q <= target;
        match_q  <= 1'b0;
      end
      if (check_now) begin
        match_q <= (calc_out == target_q);
      end
    end
  end

  // Step table; operands only leave zero/ADD while a step is in flight.
  always_comb begin
    op_sel      = OP_ADD;
    operand_sel = 3'd0;
    if (state_q == S_PULSE || state_q == S_GAP) begin
      case (step_q)
        3'd0: begin op_sel = OP_LSH; operand_sel = 3'd7;                 end
        3'd1: begin op_sel = OP_LSH; operand_sel = 3'd1;                 end
        3'd2: begin op_sel = OP_ADD; operand_sel = target_q[7:5];        end
        3'd3: begin op_sel = OP_LSH; operand_sel = 3'd3;                 end
        3'd4: begin op_sel = OP_XOR; operand_sel = target_q[4:2];        end
        3'd5: begin op_sel = OP_LSH; operand_sel = 3'd2;                 end
        3'd6: begin op_sel = OP_XOR; operand_sel = {1'b0, target_q[1:0]}; end
        default: begin op_sel = OP_ADD; operand_sel = 3'd0;              end
      endcase
    end
  end

  assign en      = pulser_en;
  assign in      = operand_sel;
  assign arithOp = op_sel;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_CHECK);
  assign match   = match_q;

endmodule

// File: tb/tb_sophiali_math_driver.sv
// Bench: two drivers (1/1 and 3/2 en timing), each feeding a behavioural
// accumulator calculator that applies one operation per en rising edge.
module tb_sophiali_math_driver;

  logic       clock = 1'b0;
  logic       reset;
  logic       start_s  [2];
  logic [7:0] target_s [2];
  logic [7:0] acc      [2] = '{8'h5A, 8'hC3};
  logic       en_s     [2];
  logic [2:0] in_s     [2];
  logic [1:0] op_s     [2];
  logic       busy_s   [2];
  logic       done_s   [2];
  logic       match_s  [2];

  int         eh_c  [2] = '{1, 3};
  int         per_c [2] = '{2, 5};

  int         k       [2] = '{0, 0};
  logic [7:0] tgt_m   [2];
  logic       mmatch  [2] = '{1'b0, 1'b0};
  logic       en_q    [2];
  int         pcnt    [2] = '{0, 0};
  logic       load_req[2];
  logic [7:0] load_val[2];
  bit         mvalid = 1'b0;
  logic [4:0] op_log[$];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  sophiali_math_driver #(.EN_HIGH(1), .EN_LOW(1)) dut0 (
    .clock(clock), .reset(reset), .start(start_s[0]), .target(target_s[0]),
    .calc_out(acc[0]), .en(en_s[0]), .in(in_s[0]), .arithOp(op_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .match(match_s[0])
  );

  sophiali_math_driver #(.EN_HIGH(3), .EN_LOW(2)) dut1 (
    .clock(clock), .reset(reset), .start(start_s[1]), .target(target_s[1]),
    .calc_out(acc[1]), .en(en_s[1]), .in(in_s[1]), .arithOp(op_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .match(match_s[1])
  );

  // Recipe as written in the requirements, returned as {operand, opcode}.
  function automatic logic [4:0] table_entry(input int step, input logic [7:0] t);
    case (step)
      0: return {3'd7, 2'b11};
      1: return {3'd1, 2'b11};
      2: return {t[7:5], 2'b00};
      3: return {3'd3, 2'b11};
      4: return {t[4:2], 2'b10};
      5: return {3'd2, 2'b11};
      6: return {1'b0, t[1:0], 2'b10};
      default: return 5'd0;
    endcase
  endfunction

  // Calculator arithmetic.
  function automatic logic [7:0] calc_apply(input logic [7:0] a, input logic [1:0] op, input logic [2:0] b);
    case (op)
      2'b00: return a + {5'd0, b};
      2'b01: return a - {5'd0, b};
      2'b10: return a ^ {5'd0, b};
      default: return a << b;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Calculator models plus a cycle-position model of each driver.
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      en_q[i] <= en_s[i];
      if (load_req[i] === 1'b1) begin
        acc[i] <= load_val[i];
      end else if (en_s[i] === 1'b1 && en_q[i] !== 1'b1) begin
        acc[i]  <= calc_apply(acc[i], op_s[i], in_s[i]);
        pcnt[i] <= pcnt[i] + 1;
        if (i == 0) op_log.push_back({in_s[0], op_s[0]});
      end
      if (reset) begin
        k[i]      <= 0;
        mmatch[i] <= 1'b0;
      end else if (k[i] == 0) begin
        if (start_s[i]) begin
          k[i]      <= 1;
          tgt_m[i]  <= target_s[i];
          mmatch[i] <= 1'b0;
          pcnt[i]   <= 0;
        end
      end else if (k[i] == 7 * per_c[i] + 1) begin
        k[i] <= 0;
      end else begin
        k[i] <= k[i] + 1;
        if (k[i] == 7 * per_c[i]) mmatch[i] <= 1'b1;
      end
    end
    if (reset) mvalid <= 1'b1;
  end

  // Every-cycle comparison of both drivers against the model.
  always @(negedge clock) begin
    if (mvalid) begin
      for (int i = 0; i < 2; i++) begin
        int kk;
        int pp;
        logic exp_en;
        logic [4:0] ent;
        kk = k[i];
        pp = per_c[i];
        exp_en = (kk >= 1) && (kk <= 7 * pp) && (((kk - 1) % pp) < eh_c[i]);
        checkOutput($sformatf("en%0d", i), en_s[i], exp_en);
        checkOutput($sformatf("busy%0d", i), busy_s[i], kk != 0);
        checkOutput($sformatf("done%0d", i), done_s[i], kk == 7 * pp + 1);
        checkOutput($sformatf("match%0d", i), match_s[i], mmatch[i]);
        if (kk <= 7 * pp) begin
          ent = (kk == 0) ? 5'd0 : table_entry((kk - 1) / pp, tgt_m[i]);
          checkOutput($sformatf("in%0d", i), in_s[i], ent[4:2]);
          checkOutput($sformatf("op%0d", i), op_s[i], ent[1:0]);
        end
        if (kk == 7 * pp + 1) begin
          checkOutput($sformatf("calc_at_done%0d", i), acc[i], tgt_m[i]);
          checkOutput($sformatf("pulses_at_done%0d", i), pcnt[i], 7);
        end
      end
    end
  end

  // One start request; glitch_at (if nonzero) re-pulses start with another target mid-run.
  task automatic applyStimulus(input int inst, input logic [7:0] tgt, input int glitch_at,
                               input logic [7:0] glitch_tgt, output int lat);
    @(negedge clock);
    target_s[inst] = tgt;
    start_s[inst]  = 1'b1;
    @(negedge clock);
    start_s[inst] = 1'b0;
    lat = 1;
    while (done_s[inst] !== 1'b1 && lat < 200) begin
      @(negedge clock);
      lat++;
      if (lat == glitch_at) begin
        start_s[inst]  = 1'b1;
        target_s[inst] = glitch_tgt;
      end else begin
        start_s[inst] = 1'b0;
      end
    end
    checkOutput($sformatf("done_seen%0d", inst), done_s[inst], 1);
  endtask

  logic [4:0] dc_exp[7] = '{{3'd7, 2'd3}, {3'd1, 2'd3}, {3'd6, 2'd0}, {3'd3, 2'd3},
                            {3'd7, 2'd2}, {3'd2, 2'd3}, {3'd0, 2'd2}};

  // Directed scenarios.
  initial begin
    int lat;
    int cyc;
    int en_seen;
    reset       = 1'b1;
    start_s     = '{1'b0, 1'b0};
    target_s    = '{8'd0, 8'd0};
    load_req    = '{1'b0, 1'b0};
    load_val    = '{8'd0, 8'd0};
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_en", en_s[0], 0);
    checkOutput("rst_in", in_s[0], 0);
    checkOutput("rst_op", op_s[0], 0);
    checkOutput("rst_busy", busy_s[0], 0);
    checkOutput("rst_done", done_s[0], 0);
    checkOutput("rst_match", match_s[0], 0);
    checkOutput("rst_en1", en_s[1], 0);
    reset = 1'b0;

    $display("[TB] target 0xDC with 1/1 timing");
    op_log.delete();
    applyStimulus(0, 8'hDC, 0, 8'h00, lat);
    checkOutput("dc_latency", lat, 15);
    checkOutput("dc_calc", acc[0], 8'hDC);
    checkOutput("dc_match", match_s[0], 1);
    checkOutput("dc_pulses", op_log.size(), 7);
    for (int j = 0; j < 7; j++) begin
      if (j < op_log.size()) checkOutput($sformatf("dc_seq%0d", j), op_log[j], dc_exp[j]);
    end

    $display("[TB] preload 0xFF then target 0x00");
    @(negedge clock);
    load_val[0] = 8'hFF;
    load_req[0] = 1'b1;
    @(negedge clock);
    load_req[0] = 1'b0;
    checkOutput("preload", acc[0], 8'hFF);
    applyStimulus(0, 8'h00, 0, 8'h00, lat);
    checkOutput("zero_calc", acc[0], 8'h00);
    checkOutput("zero_match", match_s[0], 1);

    $display("[TB] back-to-back sweep of all targets");
    @(negedge clock);
    target_s[0] = 8'd0;
    start_s[0]  = 1'b1;
    for (int t = 0; t < 256; t++) begin
      cyc = 0;
      do begin
        @(negedge clock);
        cyc++;
      end while (done_s[0] !== 1'b1 && cyc < 100);
      checkOutput($sformatf("sweep_done_%0d", t), done_s[0], 1);
      checkOutput($sformatf("sweep_calc_%0d", t), acc[0], t);
      target_s[0] = 8'(t + 1);
      if (t == 255) start_s[0] = 1'b0;
    end

    $display("[TB] 3/2 timing, target 0xA5");
    applyStimulus(1, 8'hA5, 0, 8'h00, lat);
    checkOutput("slow_latency", lat, 36);
    checkOutput("slow_calc", acc[1], 8'hA5);
    checkOutput("slow_pulses", pcnt[1], 7);
    checkOutput("slow_match", match_s[1], 1);

    $display("[TB] reset during step 4");
    @(negedge clock);
    target_s[0] = 8'h77;
    start_s[0]  = 1'b1;
    @(negedge clock);
    start_s[0] = 1'b0;
    lat = 1;
    while (lat < 9) begin
      @(negedge clock);
      lat++;
    end
    checkOutput("pre_rst_en", en_s[0], 1);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("post_rst_en", en_s[0], 0);
    checkOutput("post_rst_busy", busy_s[0], 0);
    reset = 1'b0;
    en_seen = 0;
    repeat (20) begin
      @(negedge clock);
      if (en_s[0] !== 1'b0) en_seen++;
    end
    checkOutput("no_pulse_after_rst", en_seen, 0);
    applyStimulus(0, 8'h3C, 0, 8'h00, lat);
    checkOutput("rst_restart_latency", lat, 15);
    checkOutput("rst_restart_calc", acc[0], 8'h3C);
    checkOutput("rst_restart_match", match_s[0], 1);

    $display("[TB] start while busy is ignored");
    applyStimulus(0, 8'h5A, 5, 8'h33, lat);
    checkOutput("ignore_latency", lat, 15);
    checkOutput("ignore_calc", acc[0], 8'h5A);
    checkOutput("ignore_match", match_s[0], 1);

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
